ysyx_23060077_riscv_trap_ctrl: RTL and testbench
================================================

# ysyx_23060077_riscv_trap_ctrl

Sequencer for machine-mode trap entry and return. It accepts ecall, ebreak, illegal-instruction and mret requests from EXU, and, when configured, machine timer interrupts. It performs the required CSR updates one per cycle through the single CSR write port, then issues a one-cycle PC redirect to IFU. It sits between EXU, the CSR register file and IFU, and owns the CSR write port whenever `busy` is high.

## Interface
- DATA_WIDTH, 32, data/PC width
- CSR_WIDTH, 12, CSR address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  trap/return request from EXU
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
- req_type  in  2  00 ecall, 01 ebreak, 10 illegal, 11 mret
- req_pc  in  DATA_WIDTH  PC of the requesting instruction
- irq_timer  in  1  level timer interrupt (used only with macro)
- irq_pc  in  DATA_WIDTH  PC of the next instruction, to be saved on interrupt
- csr_mstatus, csr_mtvec, csr_mepc  in  DATA_WIDTH  current CSR values
- csr_wr_en  out  1  CSR write strobe
- csr_wr_addr  out  CSR_WIDTH  CSR write address
- csr_wr_data  out  DATA_WIDTH  CSR write data
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  DATA_WIDTH  redirect target
- busy  out  1  state != IDLE; EXU must not issue CSR instructions while high

## Operation
- Fixed CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, M_STATUS, REDIR.
- IDLE, accept of a non-mret request:
  - capture req_pc into epc_r
  - capture cause into cause_r: ecall 11, ebreak 3, illegal 2
  - go to W_EPC
- IDLE, accept of mret: go to M_STATUS.
- W_EPC: write 0x341 with epc_r, then go to W_CAUSE.
- W_CAUSE: write 0x342 with cause_r, then go to W_STATUS.
- W_STATUS: write 0x300 with csr_mstatus modified as follows, then go to REDIR:
  - MPIE (bit 7) = MIE (bit 3)
  - MIE = 0
  - MPP (bits 12:11) = 2'b11
  - all other bits unchanged
- M_STATUS: write 0x300 with csr_mstatus modified as follows, then go to REDIR:
  - MIE = MPIE
  - MPIE = 1
  - MPP = 2'b00
  - all other bits unchanged
- REDIR: redirect_valid = 1, then go to IDLE.
  - Trap entry: redirect_pc = csr_mtvec & ~3 (direct mode only; bits 1:0 ignored).
  - mret: redirect_pc = csr_mepc.
- mstatus is read combinationally in its write state, never earlier. This lets the CSR file's registered mepc/mcause writes settle first.
- When csr_wr_en = 0, csr_wr_addr and csr_wr_data are 0.
- redirect_pc is 0 when redirect_valid = 0.

## Timing
- Reset value of every output: req_ready 1, busy 0, csr_wr_en 0, csr_wr_addr 0, csr_wr_data 0, redirect_valid 0, redirect_pc 0.
- Reset state is IDLE; internal registers reset to 0.
- Trap: accept at cycle T.
  - mepc write T+1, mcause write T+2, mstatus write T+3
  - redirect T+4; req_ready high again T+5
- mret: accept at T; mstatus write T+1, redirect T+2.
- Exactly one CSR write per cycle; no write in IDLE or REDIR.
- req_valid while busy is ignored, not queued. EXU must hold req_valid until accepted.
- Reset asserted mid-sequence: immediate return to IDLE and outputs to reset values.
  - Remaining writes and the redirect are abandoned.
  - CSR writes already performed stand.

## Configuration
- Macro YSYX_23060077_TIMER_IRQ_EN.
- Defined: in IDLE, if irq_timer = 1, csr_mstatus[3] = 1 and req_valid = 0:
  - take an interrupt with epc_r = irq_pc and cause_r = 32'h8000_0007
  - run the trap sequence (W_EPC, W_CAUSE, W_STATUS, REDIR)
  - req_ready is 0 in that cycle
  - if req_valid = 1 in the same cycle, the synchronous request wins; the interrupt is re-evaluated at the next IDLE cycle
- Undefined: irq_timer and irq_pc are ignored; no interrupt logic is synthesized.

## Test plan
- Reset then ecall at req_pc 0x8000_0010, mtvec 0x8000_0101, mstatus 0x0000_0008 -> writes (0x341, 0x8000_0010), (0x342, 11), (0x300, 0x0000_1880) on T+1..T+3; redirect_pc 0x8000_0100 at T+4.
- mret with mepc 0x8000_0014, mstatus 0x0000_1880 -> write (0x300, 0x0000_0088) at T+1; redirect_pc 0x8000_0014 at T+2; req_ready 1 at T+3.
- ebreak then illegal back-to-back with req_valid held high -> mcause 3 then 2; second accept at T+5; busy high exactly 4 cycles each.
- rst_n dropped at W_CAUSE of an ecall -> outputs at reset values asynchronously; no mstatus write and no redirect after release.
- (macro) irq_timer = 1, MIE = 1, irq_pc 0x8000_0200 -> mcause 0x8000_0007, mepc 0x8000_0200. Same with MIE = 0 -> no action. irq_timer and ecall in the same cycle -> ecall first, interrupt follows after its REDIR if MIE is still 1.

Source files
------------

// File: rtl/ysyx_23060077_riscv_trap_ctrl_if.sv
// ysyx_23060077_riscv_trap_ctrl_if: EXU request, CSR port and IFU redirect bundle for the trap sequencer.
interface ysyx_23060077_riscv_trap_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_WIDTH  = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_type;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  irq_timer;
  logic [DATA_WIDTH-1:0] irq_pc;
  logic [DATA_WIDTH-1:0] csr_mstatus;
  logic [DATA_WIDTH-1:0] csr_mtvec;
  logic [DATA_WIDTH-1:0] csr_mepc;
  logic                  csr_wr_en;
  logic [CSR_WIDTH-1:0]  csr_wr_addr;
  logic [DATA_WIDTH-1:0] csr_wr_data;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  busy;
  modport master (
    output req_valid, req_type, req_pc, irq_timer, irq_pc, csr_mstatus, csr_mtvec, csr_mepc,
    input  req_ready, csr_wr_en, csr_wr_addr, csr_wr_data, redirect_valid, redirect_pc, busy
  );
  modport slave (
    input  req_valid, req_type, req_pc, irq_timer, irq_pc, csr_mstatus, csr_mtvec, csr_mepc,
    output req_ready, csr_wr_en, csr_wr_addr, csr_wr_data, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/ysyx_23060077_riscv_trap_ctrl.sv
// ysyx_23060077_riscv_trap_ctrl: M-mode trap entry/mret sequencer, one CSR write per cycle then a PC redirect.
// Define YSYX_23060077_TIMER_IRQ_EN to take machine timer interrupts from IDLE.
module ysyx_23060077_riscv_trap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_WIDTH  = 12
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060077_riscv_trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, M_STATUS, REDIR} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d, cause_q, cause_d;
  logic                  mret_q, mret_d;
  logic                  irq_take, accept;
  logic [DATA_WIDTH-1:0] st, trap_st, mret_st;
  always_comb begin
`ifdef YSYX_23060077_TIMER_IRQ_EN
    irq_take = (state_q == IDLE) & bus.irq_timer & bus.csr_mstatus[3] & ~bus.req_valid;
`else
    irq_take = 1'b0;
`endif
    bus.req_ready = (state_q == IDLE) & ~irq_take;
    accept = bus.req_valid & bus.req_ready;
    state_d = state_q;
    epc_d = epc_q;
    cause_d = cause_q;
    mret_d = mret_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mret_d = bus.req_type == 2'b11;
          state_d = mret_d ? M_STATUS : W_EPC;
          epc_d = mret_d ? epc_q : bus.req_pc;
          cause_d = mret_d ? cause_q : bus.req_type == 2'b00 ? DATA_WIDTH'(11) :
                    bus.req_type == 2'b01 ? DATA_WIDTH'(3) : DATA_WIDTH'(2);
        end else if (irq_take) begin
          mret_d = 1'b0;
          state_d = W_EPC;
          epc_d = bus.irq_pc;
          cause_d = {1'b1, (DATA_WIDTH-1)'(7)};
        end
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = REDIR;
      M_STATUS: state_d = REDIR;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q <= '0;
      cause_q <= '0;
      mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
      mret_q <= mret_d;
    end
  end
  // mstatus is sampled only in its own write state so earlier CSR writes have landed
  always_comb begin
    st = bus.csr_mstatus;
    trap_st = {st[DATA_WIDTH-1:13], 2'b11, st[10:8], st[3], st[6:4], 1'b0, st[2:0]};
    mret_st = {st[DATA_WIDTH-1:13], 2'b00, st[10:8], 1'b1, st[6:4], st[7], st[2:0]};
    bus.busy = state_q != IDLE;
    bus.csr_wr_en = bus.busy & (state_q != REDIR);
    bus.csr_wr_addr = state_q == W_EPC   ? CSR_WIDTH'(12'h341) :
                      state_q == W_CAUSE ? CSR_WIDTH'(12'h342) :
                      (state_q == W_STATUS || state_q == M_STATUS) ? CSR_WIDTH'(12'h300) : '0;
    bus.csr_wr_data = state_q == W_EPC    ? epc_q :
                      state_q == W_CAUSE  ? cause_q :
                      state_q == W_STATUS ? trap_st :
                      state_q == M_STATUS ? mret_st : '0;
    bus.redirect_valid = state_q == REDIR;
    bus.redirect_pc = !bus.redirect_valid ? '0 :
                      mret_q ? bus.csr_mepc : bus.csr_mtvec & ~DATA_WIDTH'(3);
  end
endmodule

// File: tb/tb_ysyx_23060077_riscv_trap_ctrl.sv
// tb_ysyx_23060077_riscv_trap_ctrl: directed vectors for the trap sequencer.
module tb_ysyx_23060077_riscv_trap_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  ysyx_23060077_riscv_trap_ctrl_if #(.DATA_WIDTH(32), .CSR_WIDTH(12)) t ();
  ysyx_23060077_riscv_trap_ctrl #(.DATA_WIDTH(32), .CSR_WIDTH(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(t.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic rdy, input logic bsy, input logic we,
                      input logic [11:0] addr, input logic [31:0] data, input logic rv,
                      input logic [31:0] rpc);
    chk({tag, ".ready"}, 32'(t.req_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(t.busy), 32'(bsy));
    chk({tag, ".we"}, 32'(t.csr_wr_en), 32'(we));
    chk({tag, ".addr"}, 32'(t.csr_wr_addr), 32'(addr));
    chk({tag, ".data"}, t.csr_wr_data, data);
    chk({tag, ".rv"}, 32'(t.redirect_valid), 32'(rv));
    chk({tag, ".rpc"}, t.redirect_pc, rpc);
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    t.req_valid = 0; t.req_type = 0; t.req_pc = 0; t.irq_timer = 0; t.irq_pc = 0;
    t.csr_mstatus = 0; t.csr_mtvec = 0; t.csr_mepc = 0;
    #12;
    outs("reset", 1, 0, 0, 12'h0, 0, 0, 0);
    cyc(); rst_n = 1;
    // ecall
    cyc();
    t.req_valid = 1; t.req_type = 2'b00; t.req_pc = 32'h8000_0010;
    t.csr_mtvec = 32'h8000_0101; t.csr_mstatus = 32'h0000_0008;
    #1 chk("ecall.accept_ready", 32'(t.req_ready), 1);
    cyc(); t.req_valid = 0;
    outs("ecall.mepc", 0, 1, 1, 12'h341, 32'h8000_0010, 0, 0);
    cyc(); outs("ecall.mcause", 0, 1, 1, 12'h342, 32'd11, 0, 0);
    cyc(); outs("ecall.mstatus", 0, 1, 1, 12'h300, 32'h0000_1880, 0, 0);
    cyc(); outs("ecall.redir", 0, 1, 0, 12'h0, 0, 1, 32'h8000_0100);
    cyc(); outs("ecall.idle", 1, 0, 0, 12'h0, 0, 0, 0);
    // mret
    t.csr_mepc = 32'h8000_0014; t.csr_mstatus = 32'h0000_1880;
    t.req_valid = 1; t.req_type = 2'b11;
    cyc(); t.req_valid = 0;
    outs("mret.mstatus", 0, 1, 1, 12'h300, 32'h0000_0088, 0, 0);
    cyc(); outs("mret.redir", 0, 1, 0, 12'h0, 0, 1, 32'h8000_0014);
    cyc(); outs("mret.idle", 1, 0, 0, 12'h0, 0, 0, 0);
    // ebreak then illegal, req_valid held high
    t.csr_mstatus = 32'h0; t.req_valid = 1; t.req_type = 2'b01; t.req_pc = 32'h0000_0100;
    cyc(); outs("ebrk.mepc", 0, 1, 1, 12'h341, 32'h0000_0100, 0, 0);
    t.req_type = 2'b10; t.req_pc = 32'h0000_0200;
    cyc(); outs("ebrk.mcause", 0, 1, 1, 12'h342, 32'd3, 0, 0);
    cyc(); outs("ebrk.mstatus", 0, 1, 1, 12'h300, 32'h0000_1800, 0, 0);
    cyc(); outs("ebrk.redir", 0, 1, 0, 12'h0, 0, 1, 32'h8000_0100);
    cyc(); outs("ill.accept", 1, 0, 0, 12'h0, 0, 0, 0);
    cyc(); outs("ill.mepc", 0, 1, 1, 12'h341, 32'h0000_0200, 0, 0);
    cyc(); outs("ill.mcause", 0, 1, 1, 12'h342, 32'd2, 0, 0);
    t.req_valid = 0;
    cyc(); outs("ill.mstatus", 0, 1, 1, 12'h300, 32'h0000_1800, 0, 0);
    cyc(); outs("ill.redir", 0, 1, 0, 12'h0, 0, 1, 32'h8000_0100);
    cyc(); outs("ill.idle", 1, 0, 0, 12'h0, 0, 0, 0);
    // reset dropped during W_CAUSE
    t.csr_mstatus = 32'h8; t.req_valid = 1; t.req_type = 2'b00; t.req_pc = 32'h0000_0300;
    cyc(); t.req_valid = 0;
    cyc(); outs("rst.mcause", 0, 1, 1, 12'h342, 32'd11, 0, 0);
    #2 rst_n = 0;
    #1 outs("rst.async", 1, 0, 0, 12'h0, 0, 0, 0);
    cyc(); rst_n = 1;
    cyc(); outs("rst.after1", 1, 0, 0, 12'h0, 0, 0, 0);
    cyc(); outs("rst.after2", 1, 0, 0, 12'h0, 0, 0, 0);
`ifdef YSYX_23060077_TIMER_IRQ_EN
    // timer interrupt taken with MIE=1
    t.irq_timer = 1; t.irq_pc = 32'h8000_0200; t.csr_mstatus = 32'h8;
    #1 chk("irq.ready_low", 32'(t.req_ready), 0);
    cyc(); t.irq_timer = 0;
    outs("irq.mepc", 0, 1, 1, 12'h341, 32'h8000_0200, 0, 0);
    cyc(); outs("irq.mcause", 0, 1, 1, 12'h342, 32'h8000_0007, 0, 0);
    cyc(); outs("irq.mstatus", 0, 1, 1, 12'h300, 32'h0000_1880, 0, 0);
    cyc(); outs("irq.redir", 0, 1, 0, 12'h0, 0, 1, 32'h8000_0100);
    // masked with MIE=0
    cyc(); t.irq_timer = 1; t.csr_mstatus = 32'h0;
    #1 chk("irqm.ready", 32'(t.req_ready), 1);
    cyc(); outs("irqm.idle", 1, 0, 0, 12'h0, 0, 0, 0);
    // ecall and interrupt together: ecall first
    t.csr_mstatus = 32'h8; t.req_valid = 1; t.req_type = 2'b00; t.req_pc = 32'h0000_0400;
    #1 chk("both.ready", 32'(t.req_ready), 1);
    cyc(); t.req_valid = 0;
    outs("both.mepc", 0, 1, 1, 12'h341, 32'h0000_0400, 0, 0);
    cyc(); cyc(); cyc();
    cyc(); chk("both.irq_ready", 32'(t.req_ready), 0);
    cyc(); t.irq_timer = 0;
    outs("both.irq_mepc", 0, 1, 1, 12'h341, 32'h8000_0200, 0, 0);
    cyc(); outs("both.irq_mcause", 0, 1, 1, 12'h342, 32'h8000_0007, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
